game_control: RTL and testbench
===============================

GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 Parameter WIN_VALUE, default 12'd2048, tile value that sets won.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles to wait for ready after enable rises.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero spawn-LFSR reset value.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 btn  in  4  raw direction buttons, one-hot, same encoding as direction.
REQ-008 new_game  in  1  level; sampled only in S_IDLE; starts a fresh board.
REQ-009 ready  in  1  move engine done; valid only while enable=1.
REQ-010 matrix_D  in  12x[3:0][3:0]  move engine result board.
REQ-011 matrix  out  12x[3:0][3:0]  registered board driven to the move engine; [row][col], row 3 = top.
REQ-012 direction  out  4  latched one-hot direction to the move engine.
REQ-013 enable  out  1  move request to the move engine.
REQ-014 busy  out  1  high in every state except S_IDLE.
REQ-015 won, lost  out  1 each  sticky game-over flags.
REQ-016 error  out  1  one-cycle pulse on move timeout.

Function
REQ-017 FSM states SHALL be S_INIT, S_IDLE, S_REQ, S_COMMIT, S_SPAWN, S_CHECK; all outputs Moore/registered.
REQ-018 LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state; never zero.
REQ-019 btn registered once into btn_q; accept = btn_q one-hot AND previous btn_q == 0 (rising edge, full release required between moves).
REQ-020 S_IDLE: new_game=1 -> clear board, clear won/lost, S_INIT (priority over btn); accept with won=0 and lost=0 -> latch direction, S_REQ; otherwise stay; non-one-hot or multi-bit btn ignored.
REQ-021 S_REQ: enable=1, direction stable; ready=1 -> S_COMMIT; TIMEOUT cycles without ready -> pulse error, board unchanged, S_IDLE.
REQ-022 enable SHALL go high in the cycle after the accepting edge and low in the cycle after ready is sampled high.
REQ-023 S_COMMIT: matrix_D != matrix -> matrix <= matrix_D, S_SPAWN; identical -> S_IDLE, no spawn (no-op move).
REQ-024 S_SPAWN: start index = lfsr[3:0] (row = idx[3:2], col = idx[1:0]); test one cell per cycle, idx+1 mod 16; first zero cell gets 12'd4 if lfsr[7:4]==0 else 12'd2, then leave; 16 cells tested with none zero -> leave, no write.
REQ-025 S_SPAWN exit: to S_CHECK, except during init, where it returns to S_SPAWN until two tiles are placed, then S_IDLE.
REQ-026 S_CHECK (single cycle): won <= 1 if any cell == WIN_VALUE; lost <= 1 if no zero cell and no horizontally or vertically adjacent equal nonzero pair; -> S_IDLE.
REQ-027 won and lost SHALL hold until reset or new_game; while either is set, btn is ignored.
REQ-028 ready while enable=0 SHALL be ignored; ready and timeout expiring in the same cycle -> ready wins.

Reset
REQ-029 rst=0 SHALL immediately force matrix all zero, direction=0, enable=0, won=0, lost=0, error=0, LFSR=LFSR_SEED, state S_INIT.
REQ-030 After rst release, S_INIT SHALL place exactly two tiles via S_SPAWN, then enter S_IDLE with busy=0.
REQ-031 rst asserted mid-S_REQ SHALL drop enable asynchronously and discard the pending move.

Verification
REQ-032 Reset release -> busy high, then S_IDLE within 40 cycles, exactly two nonzero cells, each 2 or 4.
REQ-033 Board row0 {16,16,0,2}, btn=4'b0001 held, engine returns ready after 5 cycles with changed board -> enable high exactly 5 cycles, matrix = matrix_D plus one new 2/4 tile, busy low after S_CHECK.
REQ-034 Engine returns matrix_D == matrix -> no tile added, S_IDLE next, board bit-identical.
REQ-035 btn held high across two moves -> only one move issued; btn=4'b0011 -> no move.
REQ-036 ready never asserted -> error pulses once at cycle TIMEOUT, enable low, board unchanged.
REQ-037 matrix_D containing 2048 -> won=1, further btn ignored; full board {2,4,2,4 / 4,2,4,2 / ...} after spawn -> lost=1; new_game -> both cleared and two fresh tiles.

Source files
------------

// File: rtl/game_control.sv
// 2048-style game controller: owns the board, hands moves to an external move
// engine, spawns new tiles from an LFSR and flags win/loss.
module game_control #(
    parameter logic [11:0] WIN_VALUE = 12'd2048,
    parameter int          TIMEOUT   = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            btn,
    input  logic                  new_game,
    input  logic                  ready,
    input  logic [3:0][3:0][11:0] matrix_D,
    output logic [3:0][3:0][11:0] matrix,
    output logic [3:0]            direction,
    output logic                  enable,
    output logic                  busy,
    output logic                  won,
    output logic                  lost,
    output logic                  error
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_REQ, S_COMMIT, S_SPAWN, S_CHECK
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [3:0]    btn_q;
    logic [3:0]    btn_prev;
    logic [TW-1:0] tcnt;
    logic [3:0]    spawn_idx;
    logic [3:0]    spawn_cnt;
    logic          init_mode;
    logic          placed;

    logic accept;
    logic cell_zero;
    logic spawn_exit;
    logic has_win;
    logic has_zero;
    logic has_pair;

    // A press counts only on a clean one-hot rising edge from an all-released state.
    assign accept     = (btn_q != 4'd0) && ((btn_q & (btn_q - 4'd1)) == 4'd0) && (btn_prev == 4'd0);
    assign cell_zero  = (matrix[spawn_idx[3:2]][spawn_idx[1:0]] == 12'd0);
    assign spawn_exit = cell_zero || (spawn_cnt == 4'd15);

    always_comb begin
        has_win  = 1'b0;
        has_zero = 1'b0;
        has_pair = 1'b0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (matrix[r][c] == WIN_VALUE) has_win = 1'b1;
                if (matrix[r][c] == 12'd0) has_zero = 1'b1;
            end
        end
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (matrix[r][c] != 12'd0 && matrix[r][c] == matrix[r+1][c]) has_pair = 1'b1;
            end
        end
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                if (matrix[r][c] != 12'd0 && matrix[r][c] == matrix[r][c+1]) has_pair = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT;
            lfsr      <= LFSR_SEED;
            btn_q     <= '0;
            btn_prev  <= '0;
            tcnt      <= '0;
            spawn_idx <= '0;
            spawn_cnt <= '0;
            init_mode <= 1'b0;
            placed    <= 1'b0;
            matrix    <= '0;
            direction <= '0;
            enable    <= 1'b0;
            busy      <= 1'b1;
            won       <= 1'b0;
            lost      <= 1'b0;
            error     <= 1'b0;
        end else begin
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            btn_q    <= btn;
            btn_prev <= btn_q;
            error    <= 1'b0;
            case (state)
                S_INIT: begin
                    init_mode <= 1'b1;
                    placed    <= 1'b0;
                    spawn_idx <= lfsr[3:0];
                    spawn_cnt <= '0;
                    state     <= S_SPAWN;
                end
                S_IDLE: begin
                    if (new_game) begin
                        matrix <= '0;
                        won    <= 1'b0;
                        lost   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_INIT;
                    end else if (accept && !won && !lost) begin
                        direction <= btn_q;
                        enable    <= 1'b1;
                        tcnt      <= '0;
                        busy      <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ready) begin
                        enable <= 1'b0;
                        state  <= S_COMMIT;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        enable <= 1'b0;
                        error  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (matrix_D != matrix) begin
                        matrix    <= matrix_D;
                        spawn_idx <= lfsr[3:0];
                        spawn_cnt <= '0;
                        state     <= S_SPAWN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_SPAWN: begin
                    if (cell_zero)
                        matrix[spawn_idx[3:2]][spawn_idx[1:0]] <= (lfsr[7:4] == 4'd0) ? 12'd4 : 12'd2;
                    if (spawn_exit) begin
                        // Initial fill loops back here for the second tile instead of checking.
                        if (init_mode) begin
                            if (placed) begin
                                init_mode <= 1'b0;
                                busy      <= 1'b0;
                                state     <= S_IDLE;
                            end else begin
                                placed    <= 1'b1;
                                spawn_idx <= lfsr[3:0];
                                spawn_cnt <= '0;
                            end
                        end else begin
                            state <= S_CHECK;
                        end
                    end else begin
                        spawn_idx <= spawn_idx + 4'd1;
                        spawn_cnt <= spawn_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (has_win) won <= 1'b1;
                    if (!has_zero && !has_pair) lost <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b1;
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: the bench plays the move engine and checks
// board, handshake, timeout and game-over behaviour with immediate assertions.
module tb_game_control;

    typedef logic [3:0][3:0][11:0] board_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       new_game;
    logic       ready;
    board_t     matrix_D;
    board_t     matrix;
    logic [3:0] direction;
    logic       enable;
    logic       busy;
    logic       won;
    logic       lost;
    logic       error;

    int tests = 0;
    int fails = 0;

    game_control #(
        .WIN_VALUE(12'd2048),
        .TIMEOUT(64),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .new_game(new_game),
        .ready(ready),
        .matrix_D(matrix_D),
        .matrix(matrix),
        .direction(direction),
        .enable(enable),
        .busy(busy),
        .won(won),
        .lost(lost),
        .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int count_nz(input board_t m);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[r][c] != 12'd0) n++;
        return n;
    endfunction

    function automatic int count_bad(input board_t m);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[r][c] != 12'd0 && m[r][c] != 12'd2 && m[r][c] != 12'd4) n++;
        return n;
    endfunction

    function automatic int count_diff(input board_t m, input board_t base);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[r][c] != base[r][c]) n++;
        return n;
    endfunction

    // Differences that are not a fresh 2/4 tile in a previously empty cell.
    function automatic int count_bad_diff(input board_t m, input board_t base);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[r][c] != base[r][c] &&
                    (base[r][c] != 12'd0 || (m[r][c] != 12'd2 && m[r][c] != 12'd4))) n++;
        return n;
    endfunction

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic watch_enable(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (enable) seen++;
        end
    endtask

    // Releases buttons, presses dir and answers as the engine: ready is
    // driven so that it is sampled on the ready_at-th enable-high cycle (0 = never).
    task automatic run_move(input logic [3:0] dir, input board_t res, input int ready_at,
                            output int en_cycles, output int err_cycles,
                            output int post_cycles, output bit done);
        bit started;
        btn = 4'd0;
        repeat (3) @(negedge clk);
        btn         = dir;
        matrix_D    = res;
        en_cycles   = 0;
        err_cycles  = 0;
        post_cycles = 0;
        started     = 1'b0;
        done        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ready = 1'b0;
            if (error) err_cycles++;
            if (enable) begin
                en_cycles++;
                started = 1'b1;
                if (en_cycles == ready_at) ready = 1'b1;
            end else if (started && busy) begin
                post_cycles++;
            end
            if (started && !enable && !busy) begin
                done = 1'b1;
                break;
            end
        end
        ready = 1'b0;
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    initial begin
        board_t res;
        board_t snap;
        int     en;
        int     er;
        int     post;
        int     seen;
        bit     done;
        bit     ok;

        rst      = 1'b0;
        btn      = 4'd0;
        new_game = 1'b0;
        ready    = 1'b0;
        matrix_D = '0;
        repeat (3) @(negedge clk);

        check("rst_matrix", 32'(count_nz(matrix)), 32'd0);
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_flags", 32'({won, lost, error}), 32'd0);
        check("rst_direction", 32'(direction), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check("init_busy", 32'(busy), 32'd1);
        wait_idle(40, ok);
        check("init_idle", 32'(ok), 32'd1);
        check("init_tiles", 32'(count_nz(matrix)), 32'd2);
        check("init_values", 32'(count_bad(matrix)), 32'd0);

        // Changed board: row0 {16,16,0,2}, ready on the fifth enable cycle.
        res = '0;
        res[0][0] = 12'd16;
        res[0][1] = 12'd16;
        res[0][3] = 12'd2;
        run_move(4'b0001, res, 5, en, er, post, done);
        check("move_done", 32'(done), 32'd1);
        check("move_enable_cycles", 32'(en), 32'd5);
        check("move_error", 32'(er), 32'd0);
        check("move_direction", 32'(direction), 32'd1);
        check("move_one_new_tile", 32'(count_diff(matrix, res)), 32'd1);
        check("move_new_tile_ok", 32'(count_bad_diff(matrix, res)), 32'd0);
        check("move_post_spawn", 32'(post >= 3), 32'd1);
        check("move_flags", 32'({won, lost}), 32'd0);

        // No-op move: engine hands back the current board.
        snap = matrix;
        run_move(4'b0010, snap, 2, en, er, post, done);
        check("noop_done", 32'(done), 32'd1);
        check("noop_enable_cycles", 32'(en), 32'd2);
        check("noop_board", 32'(matrix === snap), 32'd1);
        check("noop_post_cycles", 32'(post), 32'd1);

        // Held button issues only one move; two-hot button issues none.
        snap = matrix;
        run_move(4'b0100, snap, 1, en, er, post, done);
        check("held_first_move", 32'(done), 32'd1);
        watch_enable(20, seen);
        check("held_no_second", 32'(seen), 32'd0);
        btn = 4'd0;
        repeat (3) @(negedge clk);
        btn = 4'b0011;
        watch_enable(20, seen);
        check("twohot_ignored", 32'(seen), 32'd0);
        btn = 4'd0;

        // Engine never answers: timeout.
        snap = matrix;
        run_move(4'b1000, snap, 0, en, er, post, done);
        check("timeout_done", 32'(done), 32'd1);
        check("timeout_enable_cycles", 32'(en), 32'd64);
        check("timeout_error_pulses", 32'(er), 32'd1);
        check("timeout_board", 32'(matrix === snap), 32'd1);
        check("timeout_direction", 32'(direction), 32'd8);
        @(negedge clk);
        check("timeout_error_clear", 32'(error), 32'd0);
        check("timeout_enable_low", 32'(enable), 32'd0);

        // Win, then buttons are locked out.
        res = '0;
        res[2][1] = 12'd2048;
        res[3][3] = 12'd2;
        run_move(4'b0001, res, 3, en, er, post, done);
        check("win_done", 32'(done), 32'd1);
        check("win_flag", 32'(won), 32'd1);
        check("win_not_lost", 32'(lost), 32'd0);
        btn = 4'd0;
        repeat (3) @(negedge clk);
        btn = 4'b0010;
        watch_enable(20, seen);
        check("win_locks_btn", 32'(seen), 32'd0);
        check("win_sticky", 32'(won), 32'd1);
        btn = 4'd0;

        pulse_new_game();
        wait_idle(40, ok);
        check("ng1_idle", 32'(ok), 32'd1);
        check("ng1_flags", 32'({won, lost}), 32'd0);
        check("ng1_tiles", 32'(count_nz(matrix)), 32'd2);
        check("ng1_values", 32'(count_bad(matrix)), 32'd0);

        // Loss: 8/16 checkerboard with one hole that the spawn fills.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[r][c] = ((r + c) % 2 == 0) ? 12'd8 : 12'd16;
        res[0][0] = 12'd0;
        run_move(4'b0100, res, 2, en, er, post, done);
        check("lose_done", 32'(done), 32'd1);
        check("lose_flag", 32'(lost), 32'd1);
        check("lose_not_won", 32'(won), 32'd0);
        check("lose_full", 32'(count_nz(matrix)), 32'd16);
        check("lose_fill_ok", 32'(count_bad_diff(matrix, res)), 32'd0);
        btn = 4'd0;
        repeat (3) @(negedge clk);
        btn = 4'b1000;
        watch_enable(20, seen);
        check("lose_locks_btn", 32'(seen), 32'd0);
        btn = 4'd0;

        pulse_new_game();
        wait_idle(40, ok);
        check("ng2_idle", 32'(ok), 32'd1);
        check("ng2_flags", 32'({won, lost}), 32'd0);
        check("ng2_tiles", 32'(count_nz(matrix)), 32'd2);

        // Reset during a pending request drops enable immediately.
        repeat (3) @(negedge clk);
        btn = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (enable) begin
                ok = 1'b1;
                break;
            end
        end
        check("midreq_enable_seen", 32'(ok), 32'd1);
        rst = 1'b0;
        #1;
        check("midreq_enable_drop", 32'(enable), 32'd0);
        check("midreq_matrix_clear", 32'(count_nz(matrix)), 32'd0);
        btn = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        wait_idle(40, ok);
        check("midreq_reinit", 32'(ok), 32'd1);
        check("midreq_tiles", 32'(count_nz(matrix)), 32'd2);
        check("midreq_direction", 32'(direction), 32'd0);
        check("midreq_enable_idle", 32'(enable), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
